regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Writeback controller that drives the write port of the RV32I register file: rd, we, wrs3.
- Accepts one retiring instruction per handshake from execute.
- Selects the result source: ALU, PC+4 or load.
- For loads, waits for the memory response, then aligns and sign/zero-extends the data before the write.
- Publishes a pending-destination indication to hazard logic, and reports load faults.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- TIMEOUT, 255, maximum cycles spent in WAIT_LOAD before a timeout fault. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  retiring instruction present.
- req_ready  out  1  writer can accept a request this cycle.
- req_rd  in  5  destination register.
- req_src  in  2  result source: 0=ALU, 1=PC4, 2=LOAD, 3=NONE (no write).
- req_funct3  in  3  load type: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
- req_addr_lo  in  2  low bits of the load address.
- req_alu  in  32  ALU result.
- req_pc4  in  32  PC+4.
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  32  load word, naturally aligned.
- rd  out  5  register-file write index.
- we  out  1  register-file write enable.
- wrs3  out  32  register-file write data.
- pend_valid  out  1  a destination write is outstanding.
- pend_rd  out  5  outstanding destination register.
- fault  out  1  one-cycle fault pulse.
- fault_code  out  2  fault cause: 1=misaligned, 2=bad funct3, 3=timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. All state changes on the rising edge of clk.
- Reset values: state=IDLE; rd=0, we=0, wrs3=0, pend_valid=0, pend_rd=0, fault=0, fault_code=0, timeout counter=0. req_ready is 1 in the cycle after reset deasserts.
- States:
  - IDLE: no outstanding work.
  - WAIT_LOAD: load accepted, awaiting mem_rvalid.
  - WRITE: we asserted this cycle.
- Handshake: a request is accepted on a cycle where req_valid and req_ready are both 1. req_ready = (state != WAIT_LOAD), combinational from state. Request fields are captured on acceptance.
- Non-load acceptance (src 0/1) in cycle N:
  - Cycle N+1 is WRITE with we=1, rd=req_rd, wrs3=req_alu or req_pc4.
  - Latency is 1. Back-to-back requests give one write per cycle.
- src=NONE: accepted. No write and no fault; next state IDLE.
- rd=0: we stays 0 for every source. A load with rd=0 still waits for and consumes its mem_rvalid.
- Load acceptance, checked at acceptance in this order:
  - funct3 in {3,6,7}: fault=1 and fault_code=2 next cycle; no write; next state IDLE.
  - Misaligned (LW with addr_lo!=0, LH/LHU with addr_lo[0]=1): fault=1 and fault_code=1 next cycle; no write; next state IDLE.
  - Otherwise: go to WAIT_LOAD.
- WAIT_LOAD:
  - mem_rvalid is sampled only in WAIT_LOAD, starting the cycle after acceptance. mem_rvalid in any other state is ignored.
  - On mem_rvalid: the selected byte/halfword is mem_rdata[8*addr_lo +: 8] or [8*addr_lo +: 16]. It is sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes all 32 bits.
  - The next cycle is WRITE with we=(rd!=0).
- Timeout:
  - The counter increments each WAIT_LOAD cycle without mem_rvalid.
  - When it reaches TIMEOUT (TIMEOUT!=0): fault=1 and fault_code=3 next cycle; no write; next state IDLE.
  - The counter clears on leaving WAIT_LOAD.
- Pending indication:
  - pend_valid=1 and pend_rd=captured rd whenever state is WAIT_LOAD or WRITE with a nonzero rd. Otherwise pend_valid=0 and pend_rd=0.
  - In WRITE, pend reflects the rd being written this cycle.
- WRITE and new request in the same cycle: the current write completes and the new request is accepted. The next state depends on the new request; it may be WRITE again.
- fault and we are never high in the same cycle.
- reset in any state, including WAIT_LOAD, returns to IDLE with no write. A mem_rvalid arriving later is ignored.

Decomposition:
- Shared package rv32i_pkg holds:
  - wb_src encodings (WB_ALU, WB_PC4, WB_LOAD, WB_NONE).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - fault codes.
  - wb state enum.
- One combinational sub-module, load_align: inputs funct3, addr_lo, rdata; output 32-bit extended value. It is reusable by the store/load unit.

Test Plan:
- ALU request rd=5, alu=0xDEADBEEF, accepted in cycle 10 -> cycle 11: we=1, rd=5, wrs3=0xDEADBEEF. Cycle 12: we=0.
- LB rd=3, addr_lo=2, mem_rdata=0x1280FF00 two cycles later -> one cycle after mem_rvalid: wrs3=0xFFFFFF80, we=1. Repeat as LBU -> wrs3=0x00000080.
- LH with addr_lo=1 -> next cycle fault=1, fault_code=1, we=0, req_ready=1. LW with funct3=3 -> fault_code=2.
- TIMEOUT=4, LW with rd=7 and no mem_rvalid -> pend_valid=1 and pend_rd=7 throughout the wait, then fault_code=3. A later mem_rvalid causes no write.
- Back-to-back ALU writes to rd=1,2,3 on consecutive cycles -> we high 3 consecutive cycles, in order. LW to rd=0 -> waits for mem_rvalid, we never asserted.
- reset in WAIT_LOAD, then mem_rvalid -> we=0, state IDLE, pend_valid=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the writeback path and the load/store unit.
// Holds writeback source encodings, load funct3 values, fault codes, the
// writeback FSM state type and small decode helpers for load requests.
package rv32i_pkg;

  // Writeback result source
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_PC4  = 2'd1;
  localparam logic [1:0] WB_LOAD = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Fault causes
  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_FUNCT3   = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLoad,
    StWrite
  } wb_state_e;

  // funct3 values that are not a defined load
  function automatic logic load_funct3_bad(logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  // Address not naturally aligned for the access size
  function automatic logic load_misaligned(logic [2:0] f3, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (f3 == F3_LW) begin
      mis = (addr_lo != 2'b00);
    end else if ((f3 == F3_LH) || (f3 == F3_LHU)) begin
      mis = addr_lo[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner.
// Picks the byte/halfword addressed by addr_lo out of a naturally aligned
// 32-bit word and sign- or zero-extends it according to funct3.
// Ports:
//   funct3  - load type (LB/LH/LW/LBU/LHU)
//   addr_lo - low two address bits
//   rdata   - aligned memory word
//   value   - extended 32-bit result (rdata unchanged for LW or unknown funct3)
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [31:0] shifted;

  // Move the addressed byte lane down to bit 0
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    value = rdata;
    unique case (funct3)
      F3_LB:   value = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   value = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  value = {24'd0, shifted[7:0]};
      F3_LHU:  value = {16'd0, shifted[15:0]};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// RV32I writeback controller driving the register-file write port.
// Accepts one retiring instruction per handshake, selects ALU / PC+4 / load
// result, waits for load data when needed and writes one cycle later.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake from execute
//   req_rd, req_src       - destination and result source
//   req_funct3, req_addr_lo - load type and low address bits
//   req_alu, req_pc4      - candidate results
//   mem_rvalid, mem_rdata - load response (single-cycle pulse)
//   rd, we, wrs3          - register-file write port
//   pend_valid, pend_rd   - outstanding destination for hazard logic
//   fault, fault_code     - one-cycle load fault pulse and cause
module regfile_writeback
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_rd,
  input  logic [1:0]      req_src,
  input  logic [2:0]      req_funct3,
  input  logic [1:0]      req_addr_lo,
  input  logic [XLEN-1:0] req_alu,
  input  logic [XLEN-1:0] req_pc4,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [4:0]      rd,
  output logic            we,
  output logic [XLEN-1:0] wrs3,
  output logic            pend_valid,
  output logic [4:0]      pend_rd,
  output logic            fault,
  output logic [1:0]      fault_code
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wb_state_e       state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wrs3_q, wrs3_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] load_val;

  load_align u_load_align (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .rdata   (mem_rdata),
    .value   (load_val)
  );

  assign req_ready = (state_q != StWaitLoad);

  always_comb begin
    state_d      = StIdle;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    we_d         = 1'b0;
    wrs3_d       = wrs3_q;
    fault_d      = 1'b0;
    fault_code_d = FAULT_NONE;
    cnt_d        = '0;

    if (state_q == StWaitLoad) begin
      if (mem_rvalid) begin
        state_d = StWrite;
        we_d    = (rd_q != 5'd0);
        wrs3_d  = load_val;
      end else begin
        state_d = StWaitLoad;
        if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(TIMEOUT)) begin
            state_d      = StIdle;
            fault_d      = 1'b1;
            fault_code_d = FAULT_TIMEOUT;
            cnt_d        = '0;
          end
        end
      end
    end else if (req_valid) begin
      // IDLE or WRITE: the current write (if any) finishes while accepting
      unique case (req_src)
        WB_ALU, WB_PC4: begin
          state_d = StWrite;
          rd_d    = req_rd;
          we_d    = (req_rd != 5'd0);
          wrs3_d  = (req_src == WB_ALU) ? req_alu : req_pc4;
        end
        WB_LOAD: begin
          if (load_funct3_bad(req_funct3)) begin
            fault_d      = 1'b1;
            fault_code_d = FAULT_FUNCT3;
          end else if (load_misaligned(req_funct3, req_addr_lo)) begin
            fault_d      = 1'b1;
            fault_code_d = FAULT_MISALIGN;
          end else begin
            state_d   = StWaitLoad;
            rd_d      = req_rd;
            funct3_d  = req_funct3;
            addr_lo_d = req_addr_lo;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rd_q         <= 5'd0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      we_q         <= 1'b0;
      wrs3_q       <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      we_q         <= we_d;
      wrs3_q       <= wrs3_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rd         = rd_q;
  assign we         = we_q;
  assign wrs3       = wrs3_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

  // rd_q holds the destination of the load in flight or the write in progress
  assign pend_valid = ((state_q == StWaitLoad) || (state_q == StWrite)) && (rd_q != 5'd0);
  assign pend_rd    = pend_valid ? rd_q : 5'd0;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_regfile_writeback;

  localparam int T = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [1:0]  req_src;
  logic [2:0]  req_funct3;
  logic [1:0]  req_addr_lo;
  logic [31:0] req_alu;
  logic [31:0] req_pc4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] wrs3;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        fault;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_errors = 0;

  regfile_writeback #(
    .XLEN    (32),
    .TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_src     (req_src),
    .req_funct3  (req_funct3),
    .req_addr_lo (req_addr_lo),
    .req_alu     (req_alu),
    .req_pc4     (req_pc4),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rd          (rd),
    .we          (we),
    .wrs3        (wrs3),
    .pend_valid  (pend_valid),
    .pend_rd     (pend_rd),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected fault cause for a request (0 = none)
  function automatic int ref_fault(input int src, input int f3, input int lo);
    if (src != 2) return 0;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 2;
    if (f3 == 2 && lo != 0) return 1;
    if ((f3 == 1 || f3 == 5) && (lo % 2) == 1) return 1;
    return 0;
  endfunction

  // Expected register value for a load, by arithmetic on the word
  function automatic logic [31:0] ref_load(input int f3, input int lo, input logic [31:0] w);
    int unsigned sh, b, h;
    sh = w >> (8 * lo);
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      0:       return (b >= 128) ? b - 256 : b;
      1:       return (h >= 32768) ? h - 65536 : h;
      4:       return b;
      5:       return h;
      default: return w;
    endcase
  endfunction

  // Issue one request at the current negedge and check its whole outcome.
  // d = number of wait cycles before mem_rvalid is pulsed.
  task automatic run_txn(input logic [1:0] src, input logic [4:0] r, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] word, input int d);
    int fc;
    bit done;
    bit wr;
    check("ready_before_req", req_ready, 1);
    req_valid   = 1'b1;
    req_src     = src;
    req_rd      = r;
    req_funct3  = f3;
    req_addr_lo = lo;
    req_alu     = alu;
    req_pc4     = pc4;
    tick();
    req_valid   = 1'b0;
    req_alu     = $urandom;
    req_pc4     = $urandom;
    req_rd      = 5'($urandom);
    fc = ref_fault(src, f3, lo);
    if (src != 2'd2) begin
      wr = (src != 2'd3) && (r != 5'd0);
      check("we", we, wr);
      if (wr) begin
        check("rd", rd, r);
        check("wrs3", wrs3, (src == 2'd0) ? alu : pc4);
      end
      check("fault_clear", fault, 0);
      check("pend_valid_write", pend_valid, wr);
      check("pend_rd_write", pend_rd, wr ? r : 5'd0);
    end else if (fc != 0) begin
      check("fault", fault, 1);
      check("fault_code", fault_code, fc);
      check("fault_no_we", we, 0);
      check("fault_ready", req_ready, 1);
      check("fault_pend", pend_valid, 0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < T; k++) begin
        mem_rvalid = (k == d);
        mem_rdata  = (k == d) ? word : $urandom;
        check("pend_valid_wait", pend_valid, r != 5'd0);
        check("pend_rd_wait", pend_rd, r);
        check("ready_wait", req_ready, 0);
        tick();
        mem_rvalid = 1'b0;
        if (k == d) begin
          check("load_we", we, r != 5'd0);
          if (r != 5'd0) begin
            check("load_rd", rd, r);
            check("load_data", wrs3, ref_load(f3, lo, word));
          end
          check("load_fault_clear", fault, 0);
          done = 1'b1;
          break;
        end
        check("no_early_we", we, 0);
      end
      if (!done) begin
        check("timeout_fault", fault, 1);
        check("timeout_code", fault_code, 3);
        check("timeout_pend", pend_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        check("late_rvalid_ignored", we, 0);
        check("late_rvalid_no_fault", fault, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) check("fault_we_exclusive", fault & we, 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] src;
    logic [4:0] r;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_rd      = 5'd0;
    req_src     = 2'd0;
    req_funct3  = 3'd0;
    req_addr_lo = 2'd0;
    req_alu     = 32'd0;
    req_pc4     = 32'd0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'd0;
    @(negedge clk);
    repeat (3) tick();
    check("rst_rd", rd, 0);
    check("rst_we", we, 0);
    check("rst_wrs3", wrs3, 0);
    check("rst_pend_valid", pend_valid, 0);
    check("rst_pend_rd", pend_rd, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_code", fault_code, 0);
    reset = 1'b0;
    check("rst_ready", req_ready, 1);
    tick();

    // ALU write then idle
    run_txn(2'd0, 5'd5, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 0);
    tick();
    check("alu_we_drop", we, 0);

    // LB / LBU of byte 2 of 0x1280FF00
    run_txn(2'd2, 5'd3, 3'd0, 2'd2, 32'h0, 32'h0, 32'h1280FF00, 1);
    run_txn(2'd2, 5'd3, 3'd4, 2'd2, 32'h0, 32'h0, 32'h1280FF00, 1);

    // Faults
    run_txn(2'd2, 5'd4, 3'd1, 2'd1, 32'h0, 32'h0, 32'h0, 0);
    run_txn(2'd2, 5'd4, 3'd3, 2'd0, 32'h0, 32'h0, 32'h0, 0);

    // Timeout with late response
    run_txn(2'd2, 5'd7, 3'd2, 2'd0, 32'h0, 32'h0, 32'hCAFEF00D, 10);

    // Back-to-back ALU writes, then PC4 and NONE
    run_txn(2'd0, 5'd1, 3'd0, 2'd0, 32'h11111111, 32'h0, 32'h0, 0);
    run_txn(2'd0, 5'd2, 3'd0, 2'd0, 32'h22222222, 32'h0, 32'h0, 0);
    run_txn(2'd0, 5'd3, 3'd0, 2'd0, 32'h33333333, 32'h0, 32'h0, 0);
    run_txn(2'd1, 5'd9, 3'd0, 2'd0, 32'h0, 32'h00001004, 32'h0, 0);
    run_txn(2'd3, 5'd9, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);

    // LW to x0 consumes the response without writing
    run_txn(2'd2, 5'd0, 3'd2, 2'd0, 32'h0, 32'h0, 32'h89ABCDEF, 2);

    // Reset while waiting for a load; later response ignored
    req_valid   = 1'b1;
    req_src     = 2'd2;
    req_rd      = 5'd9;
    req_funct3  = 3'd2;
    req_addr_lo = 2'd0;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_reset_pend", pend_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wait_rst_we", we, 0);
    check("wait_rst_pend", pend_valid, 0);
    check("wait_rst_ready", req_ready, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    check("wait_rst_rvalid_ignored", we, 0);
    check("wait_rst_pend_after", pend_valid, 0);

    // Randomized transactions
    for (int i = 0; i < 200; i++) begin
      src = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) src = 2'd2;
      r = 5'($urandom);
      if ($urandom_range(0, 7) == 0) r = 5'd0;
      run_txn(src, r, 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) begin
        tick();
        check("idle_we", we, 0);
        check("idle_pend", pend_valid, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
